// File: rtl/serial_sub_8bit_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_8bit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_sub_8bit_sub_full.sv
// 1-bit full-subtractor cell: diff = a ^ b ^ bin, borrow out when a < b + bin.
// Purely combinational, zero latency, no flow control.
module sub_full (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic b_out
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign diff  = w_axb ^ bin;
    assign b_out = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_sub_8bit.sv
// Bit-serial diff = a - b - bin, LSB first, one full-subtractor cell, WIDTH cycles per op.
// done pulses WIDTH edges after the accepted start; start is ignored while busy.
module serial_sub_8bit
    import serial_sub_8bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_r,
    output logic             bout_r
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_brw;
    // Holds the WIDTH-1 low result bits; the last bit joins them at commit.
    logic [WIDTH-2:0] r_res_sh;

    logic w_d;
    logic w_brw_next;
    logic w_accept;
    logic w_last;

    sub_full u_cell (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .bin   (r_brw),
        .diff  (w_d),
        .b_out (w_brw_next)
    );

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_brw    <= 1'b0;
            r_res_sh <= '0;
            diff_r   <= '0;
            bout_r   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_brw    <= w_brw_next;
                    r_res_sh <= {w_d, r_res_sh[WIDTH-2:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        diff_r  <= {w_d, r_res_sh};
                        bout_r  <= w_brw_next;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_sub_8bit.md
Name: serial_sub_8bit

Overview:
- Bit-serial 8-bit subtractor: computes diff = a − b − bin, LSB first, one bit per clock, through a single full-subtractor cell.
- Mirror of the team's registered ripple-carry adder, area-reduced: one cell instead of eight.
- Start/busy/done handshake; registered difference and borrow-out are held stable until the next completion.
- Sits beside the adder in the basic-arithmetic datapath library.

Parameters:
- WIDTH, 8, operand/result width in bits; also the number of RUN cycles.
- CNT_W, 3, width of the bit counter; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse; diff_r/bout_r updated on the same edge.
- diff_r  output  WIDTH  registered difference.
- bout_r  output  1  registered borrow-out (1 = a < b + bin, unsigned).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; busy=0, done=0, diff_r=0, bout_r=0, counter=0, shift registers=0. Reset overrides everything, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE. Outputs are decoded from registered state: busy=(RUN), done=(DONE).
- IDLE: start=1 at edge E0 → latch a, b, bin into internal registers; cnt=0; go to RUN. start=0 → stay in IDLE.
- RUN, edge Ek (k=1..WIDTH): process bit k−1:
  - d = a_sh[0] ^ b_sh[0] ^ brw
  - brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw)
  - shift a_sh, b_sh right; shift d into the MSB of the result shift register; cnt++.
- At E_WIDTH (cnt==WIDTH−1): commit the full result to diff_r and the final borrow to bout_r; go to DONE.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH edges after the start edge. busy is high for exactly WIDTH cycles.
- DONE (one cycle): start=1 → accepted exactly as in IDLE (back-to-back, no bubble), go to RUN; else go to IDLE.
- start during RUN is ignored; operand inputs are don't-care outside the accept edge.
- diff_r/bout_r change only on commit or reset; they hold through IDLE and the next RUN.
- Arithmetic is unsigned modulo 2**WIDTH. Wrap-around is reported only via bout_r; no overflow flag.

Decomposition:
- Shared package: FSM state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH.
- One sub-module: sub_full (output b_out, diff; input a, b, bin), purely combinational, the 1-bit full-subtractor cell. Instantiated once in the datapath.

Test Plan:
- a=8'h3C, b=8'h1A, bin=0, start pulse → after 8 cycles done=1, diff_r=8'h22, bout_r=0; busy high exactly 8 cycles.
- a=8'h00, b=8'h01, bin=0 → diff_r=8'hFF, bout_r=1. Then a=8'h80, b=8'h80, bin=1 → diff_r=8'hFF, bout_r=1. Then a=8'hFF, b=8'h00, bin=1 → diff_r=8'hFE, bout_r=0.
- Start accepted with a=8'h10, b=8'h05; start re-pulsed with different operands at RUN cycle 3 → ignored, result diff_r=8'h0B, bout_r=0.
- Back-to-back: start held high through the DONE cycle with a=8'h50, b=8'h20 → first done, then next done exactly 8 cycles later with diff_r=8'h30; no IDLE cycle between.
- rst=1 at RUN cycle 4 → next cycle busy=0, done=0, diff_r=0, bout_r=0, state IDLE. A subsequent start yields a correct result.
- Random 1000 operands against the reference model (a−b−bin) mod 256 plus borrow; the same vectors cross-check against the registered adder via a + ~b + ~bin identity.
